// File: rtl/serial_rx.sv
// Oversampling asynchronous serial receiver: 2-flop synchronizer, start-bit
// validation at mid-bit, LSB-first data capture and a one-deep output holding register.
module serial_rx #(
  parameter int DATA_BITS  = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [IDX_W-1:0]     idx, idx_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic [DATA_BITS-1:0] data_nx;
  logic                 valid_nx, err_nx, over_nx;
  logic                 stop_eval;
  logic                 rx_p0, rx_s;

  // Stage p0/p1: metastability synchronizer, idles high
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    shreg_nx  = shreg;
    stop_eval = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          cnt_nx   = '0;
        end
      end
      START: begin
        // A high line before mid-bit is treated as noise, not a start bit
        if (rx_s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_HALF) begin
          state_nx = DATA;
          cnt_nx   = '0;
          idx_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shreg_nx[idx] = rx_s;
          cnt_nx        = '0;
          if (idx == IDX_LAST) begin
            state_nx = STOP;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          stop_eval = 1'b1;
          state_nx  = IDLE;
          cnt_nx    = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        idx_nx   = '0;
      end
    endcase
  end

  // Output register: a load on a good stop bit wins over a concurrent handshake clear
  always_comb begin
    data_nx  = data_out;
    valid_nx = valid;
    err_nx   = 1'b0;
    over_nx  = overrun;
    if (valid && ready) begin
      valid_nx = 1'b0;
      over_nx  = 1'b0;
    end
    if (stop_eval) begin
      if (!rx_s) begin
        err_nx = 1'b1;
      end else if (!valid || ready) begin
        data_nx  = shreg;
        valid_nx = 1'b1;
      end else begin
        over_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      data_out  <= data_nx;
      valid     <= valid_nx;
      frame_err <= err_nx;
      overrun   <= over_nx;
    end
  end

  // Every bit position is rewritten by each frame, so the assembly register needs no reset
  always_ff @(posedge clk) begin
    shreg <= shreg_nx;
  end

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: directed scenarios plus randomized frames
// checked against a frame-level behavioural model of the output register.
module tb_serial_rx;
  localparam int N = 8;
  localparam int B = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         rx;
  logic         ready;
  logic [N-1:0] data_out;
  logic         valid;
  logic         frame_err;
  logic         overrun;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor observations
  int           err_cnt = 0;
  int           vld_cyc = 0;
  logic [N-1:0] got[$];

  // Behavioural model of the consumer-visible state
  logic         m_valid;
  logic [N-1:0] m_data;
  logic         m_over;
  int           exp_err;
  int           got_rd;

  serial_rx #(.DATA_BITS(N), .BIT_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .rx(rx), .ready(ready),
    .data_out(data_out), .valid(valid), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) err_cnt <= err_cnt + 1;
    if (valid) vld_cyc <= vld_cyc + 1;
    if (valid && ready) got.push_back(data_out);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [N-1:0] d, input logic stop_bit);
    rx = 1'b0;
    step(B);
    for (int i = 0; i < N; i++) begin
      rx = d[i];
      step(B);
    end
    rx = stop_bit;
    step(B);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx    = 1'b1;
    ready = 1'b0;
    step(3);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 00", data_out); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    reset   = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_over  = 1'b0;
    exp_err = err_cnt;
    got_rd  = got.size();
    step(2);
  endtask

  task automatic test_basic;
    ready = 1'b0;
    send_frame(8'hA5, 1'b1);
    step(3);
    m_valid = 1'b1; m_data = 8'hA5;
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", valid); end
    n_cmp++; if (data_out !== 8'hA5) begin n_bad++; $display("FAIL basic_data: got %h want a5", data_out); end
    n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL basic_frame_err: got %0d pulses want %0d", err_cnt, exp_err); end
    for (int i = 0; i < 8; i++) begin
      step(1);
      n_cmp++;
      if (valid !== 1'b1 || data_out !== 8'hA5) begin
        n_bad++; $display("FAIL basic_hold: got valid=%b data=%h want valid=1 data=a5", valid, data_out);
      end
    end
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    m_valid = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL basic_consume_valid: got %b want 0", valid); end
    n_cmp++;
    if (got.size() != got_rd + 1 || got[got_rd] !== 8'hA5) begin
      n_bad++; $display("FAIL basic_consume_data: got %0d entries want %0d ending in a5", got.size(), got_rd + 1);
    end
    got_rd = got.size();
  endtask

  task automatic test_glitch;
    rx = 1'b0;
    step(1);
    rx = 1'b1;
    step(4 * B);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL glitch_valid: got %b want 0", valid); end
    n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL glitch_frame_err: got %0d pulses want %0d", err_cnt, exp_err); end
    send_frame(8'h5A, 1'b1);
    step(3);
    m_valid = 1'b1; m_data = 8'h5A;
    n_cmp++;
    if (valid !== 1'b1 || data_out !== 8'h5A) begin
      n_bad++; $display("FAIL glitch_recover: got valid=%b data=%h want valid=1 data=5a", valid, data_out);
    end
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    m_valid = 1'b0;
    got_rd = got.size();
  endtask

  task automatic test_frame_err;
    send_frame(8'h3C, 1'b0);
    step(3 + B);
    exp_err++;
    n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL ferr_pulse: got %0d pulses want %0d", err_cnt, exp_err); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL ferr_valid: got %b want 0", valid); end
    n_cmp++; if (data_out !== m_data) begin n_bad++; $display("FAIL ferr_data: got %h want %h", data_out, m_data); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ferr_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_overrun;
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    step(3);
    send_frame(8'h22, 1'b1);
    step(3);
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid: got %b want 1", valid); end
    n_cmp++; if (data_out !== 8'h11) begin n_bad++; $display("FAIL ovr_data: got %h want 11", data_out); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    m_valid = 1'b0; m_data = 8'h11; m_over = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL ovr_clear_valid: got %b want 0", valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear_flag: got %b want 0", overrun); end
    n_cmp++;
    if (got.size() != got_rd + 1 || got[got_rd] !== 8'h11) begin
      n_bad++; $display("FAIL ovr_consumed: got %0d entries want %0d ending in 11", got.size(), got_rd + 1);
    end
    got_rd = got.size();
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = vld_cyc;
    ready = 1'b1;
    send_frame(8'h81, 1'b1);
    send_frame(8'h7E, 1'b1);
    step(4);
    ready = 1'b0;
    m_data = 8'h7E;
    n_cmp++;
    if (got.size() != got_rd + 2) begin
      n_bad++; $display("FAIL b2b_count: got %0d entries want %0d", got.size(), got_rd + 2);
    end else begin
      if (got[got_rd] !== 8'h81 || got[got_rd + 1] !== 8'h7E) begin
        n_bad++; $display("FAIL b2b_order: got %h,%h want 81,7e", got[got_rd], got[got_rd + 1]);
      end
    end
    got_rd = got.size();
    n_cmp++; if (vld_cyc - v0 !== 2) begin n_bad++; $display("FAIL b2b_valid_cycles: got %0d want 2", vld_cyc - v0); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_end: got %b want 0", valid); end
  endtask

  task automatic test_reset_mid;
    ready = 1'b0;
    rx = 1'b0;
    step(B);
    rx = 1'b1;
    step(3 * B);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    m_valid = 1'b0; m_data = '0; m_over = 1'b0;
    n_cmp++; if (valid !== 1'b0 || data_out !== '0) begin n_bad++; $display("FAIL rmid_cleared: got valid=%b data=%h want 0/00", valid, data_out); end
    step(B * (N + 2));
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rmid_no_ff: got valid=%b data=%h want no frame", valid, data_out); end
    send_frame(8'h0F, 1'b1);
    step(3);
    m_valid = 1'b1; m_data = 8'h0F;
    n_cmp++; if (valid !== 1'b1 || data_out !== 8'h0F) begin n_bad++; $display("FAIL rmid_data: got valid=%b data=%h want 1/0f", valid, data_out); end
    n_cmp++; if (err_cnt !== exp_err || overrun !== 1'b0) begin n_bad++; $display("FAIL rmid_flags: got err=%0d ovr=%b want %0d/0", err_cnt, overrun, exp_err); end
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    m_valid = 1'b0;
    n_cmp++;
    if (got.size() != got_rd + 1 || got[got_rd] !== 8'h0F) begin
      n_bad++; $display("FAIL rmid_delivered: got %0d entries want %0d ending in 0f", got.size(), got_rd + 1);
    end
    got_rd = got.size();
  endtask

  task automatic test_random;
    logic [N-1:0] d;
    logic         good;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        rx = 1'b0;
        step(1);
        rx = 1'b1;
        step(B);
      end
      d    = N'($urandom_range(0, 255));
      good = ($urandom_range(0, 5) != 0);
      send_frame(d, good);
      step($urandom_range(3, 8) + B);
      if (!good) exp_err++;
      else if (m_valid) m_over = 1'b1;
      else begin m_valid = 1'b1; m_data = d; end
      n_cmp++;
      if (valid !== m_valid || data_out !== m_data || overrun !== m_over || err_cnt !== exp_err) begin
        n_bad++;
        $display("FAIL rand_frame%0d: got v=%b d=%h o=%b e=%0d want v=%b d=%h o=%b e=%0d",
                 k, valid, data_out, overrun, err_cnt, m_valid, m_data, m_over, exp_err);
      end
      if ($urandom_range(0, 2) == 0) begin
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        n_cmp++;
        if (m_valid) begin
          if (got.size() != got_rd + 1 || got[got_rd] !== m_data) begin
            n_bad++; $display("FAIL rand_consume%0d: got %0d entries want %0d ending in %h", k, got.size(), got_rd + 1, m_data);
          end
          m_valid = 1'b0;
          m_over  = 1'b0;
        end else if (got.size() != got_rd) begin
          n_bad++; $display("FAIL rand_spurious%0d: got %0d entries want %0d", k, got.size(), got_rd);
        end
        got_rd = got.size();
        n_cmp++;
        if (valid !== m_valid || overrun !== m_over) begin
          n_bad++; $display("FAIL rand_after%0d: got v=%b o=%b want v=%b o=%b", k, valid, overrun, m_valid, m_over);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
